// File: rtl/mem_fifo_pkg.sv
// Shared payload type and sizing helpers for the memory-backed FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_fifo_pkg;

  typedef logic [31:0] data_t;

  // Entries held after the memory, in the registered output buffer.
  localparam int OB_DEPTH = 2;

  // Occupancy counter width: memory entries + one in-flight read + output buffer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + OB_DEPTH + 1);
  endfunction

endpackage

// File: rtl/memory_if.sv
// One port of a single-clock memory: enable, write enable, address, write and read data.
// Latency: read_data is valid the cycle after an enabled read.
// Backpressure: none; the memory accepts every enabled access.
interface memory_if #(
  parameter int ADDR_W = 4
);
  import mem_fifo_pkg::*;

  logic              enable;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  data_t             write_data;
  data_t             read_data;

  // Controller side drives the access, memory side returns read data.
  modport src (output enable, wr_en, addr, write_data, input read_data);
  modport snk (input enable, wr_en, addr, write_data, output read_data);

endinterface

// File: rtl/mem_fifo_obuf.sv
// Two-entry registered output buffer fed by memory read data, drained as valid/ready.
// Latency: captured data is visible on o_dat the cycle after capture.
// Backpressure: none on capture; the controller only issues reads it has room for.
module mem_fifo_obuf
  import mem_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cap_vld,
  input  data_t      i_cap_dat,
  output logic       o_vld,
  input  logic       i_rdy,
  output data_t      o_dat,
  output logic [1:0] o_cnt
);

  data_t      r_dat0;
  data_t      r_dat1;
  logic [1:0] r_cnt;
  logic       w_pop;

  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_dat0;
  assign o_cnt = r_cnt;
  assign w_pop = o_vld && i_rdy;

  // Head lives in r_dat0; a pop shifts r_dat1 forward, a capture fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat0 <= '0;
      r_dat1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_pop, i_cap_vld})
        2'b01: begin
          if (r_cnt == 2'd0) r_dat0 <= i_cap_dat;
          else               r_dat1 <= i_cap_dat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b10: begin
          r_dat0 <= r_dat1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_dat0 <= i_cap_dat;
          end else begin
            r_dat0 <= r_dat1;
            r_dat1 <= i_cap_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/memory_dp.sv
// Dual-port storage: port A writes (or reads), port B reads only; contents never reset.
// Latency: 1 cycle flopped read on both ports.
// Backpressure: none; every enabled access completes.
module memory_dp
  import mem_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  memory_if.snk  port_a,
  memory_if.snk  port_b
);

  data_t r_mem [DEPTH];

  // Port B carries no write path.
  logic w_unused_b;
  assign w_unused_b = ^port_b.write_data;

  // Port A: write when wr_en is high, otherwise a registered read.
  always_ff @(posedge clk) begin
    if (port_a.enable) begin
      if (port_a.wr_en) begin
        r_mem[port_a.addr] <= port_a.write_data;
      end else begin
        port_a.read_data <= r_mem[port_a.addr];
      end
    end
  end

  // Port B: registered read only.
  always_ff @(posedge clk) begin
    if (port_b.enable && !port_b.wr_en) begin
      port_b.read_data <= r_mem[port_b.addr];
    end
  end

endmodule

// File: rtl/memory_fifo_ctrl.sv
// FIFO controller using a dual-port memory as storage, with a 2-entry registered pop buffer.
// Latency: push fire N -> read issue N+1 -> read data N+2 -> pop_valid N+3 on an empty FIFO.
// Backpressure: push_ready drops when the memory is full; reads stall while the buffer is full.
// Optional high-water mark (peak_clr/peak_count) is built when MEM_FIFO_PEAK_EN is defined.
module memory_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  data_t            push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output data_t            pop_data,
  output logic [CNT_W-1:0] count,
  memory_if.src            mem_wr,
  memory_if.src            mem_rd
`ifdef MEM_FIFO_PEAK_EN
  ,
  input  logic             peak_clr,
  output logic [CNT_W-1:0] peak_count
`endif
);

  localparam logic [ADDR_W:0] MEM_FULL = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_mem_cnt;
  logic              r_inflight;
  logic              r_run;
  logic [1:0]        w_ob_cnt;
  logic              w_push_fire;
  logic              w_pop_fire;
  logic              w_rd_go;

  // Port A never reads.
  logic w_unused;
  assign w_unused = ^mem_wr.read_data;

  // r_run keeps push_ready low until the first clock after reset release.
  assign push_ready  = r_run && (r_mem_cnt != MEM_FULL);
  assign w_push_fire = push_valid && push_ready;
  assign w_pop_fire  = pop_valid && pop_ready;

  // Issue a read only if the buffer has room for it once this cycle's pop and any in-flight read land.
  assign w_rd_go = (r_mem_cnt != '0) &&
                   (({1'b0, w_ob_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop_fire}));

  assign mem_wr.enable     = w_push_fire;
  assign mem_wr.wr_en      = w_push_fire;
  assign mem_wr.addr       = r_wr_ptr;
  assign mem_wr.write_data = w_push_fire ? push_data : '0;

  assign mem_rd.enable     = w_rd_go;
  assign mem_rd.wr_en      = 1'b0;
  assign mem_rd.addr       = r_rd_ptr;
  assign mem_rd.write_data = '0;

  assign count = CNT_W'(r_mem_cnt) + CNT_W'(r_inflight) + CNT_W'(w_ob_cnt);

  // Pointers wrap naturally at DEPTH; mem_cnt tracks entries written but not yet read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_rd_go;
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_go)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_cnt <= r_mem_cnt + {{ADDR_W{1'b0}}, w_push_fire} - {{ADDR_W{1'b0}}, w_rd_go};
    end
  end

  mem_fifo_obuf u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cap_vld (r_inflight),
    .i_cap_dat (mem_rd.read_data),
    .o_vld     (pop_valid),
    .i_rdy     (pop_ready),
    .o_dat     (pop_data),
    .o_cnt     (w_ob_cnt)
  );

`ifdef MEM_FIFO_PEAK_EN
  // High-water mark of total occupancy; a clear reloads the current count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_count <= '0;
    end else if (peak_clr) begin
      peak_count <= count;
    end else if (count > peak_count) begin
      peak_count <= count;
    end
  end
`endif

endmodule

// File: tb/tb_memory_fifo_ctrl.sv
// Bench for memory_fifo_ctrl attached to memory_dp: directed vectors with a scoreboard monitor.
// Latency: checks the 3-cycle push-to-pop path and steady single-cycle throughput.
// Backpressure: exercises full memory, stalled consumer and mid-operation reset.
module tb_memory_fifo_ctrl;
  import mem_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = cnt_w(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_valid = 1'b0;
  logic             push_ready;
  data_t            push_data = '0;
  logic             pop_valid;
  logic             pop_ready = 1'b0;
  data_t            pop_data;
  logic [CNT_W-1:0] count;
`ifdef MEM_FIFO_PEAK_EN
  logic             peak_clr = 1'b0;
  logic [CNT_W-1:0] peak_count;
`endif

  int checks = 0;
  int errors = 0;

  data_t sb[$];
  int    occ = 0;
  int    wr_total = 0;
  int    rd_total = 0;
  int    pops = 0;
  data_t last_pop = '0;

  always #5 clk = ~clk;

  memory_if #(.ADDR_W($clog2(DEPTH))) wr_if ();
  memory_if #(.ADDR_W($clog2(DEPTH))) rd_if ();

  memory_dp #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .port_a (wr_if),
    .port_b (rd_if)
  );

  memory_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count),
    .mem_wr     (wr_if),
    .mem_rd     (rd_if)
`ifdef MEM_FIFO_PEAK_EN
    ,
    .peak_clr   (peak_clr),
    .peak_count (peak_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy model, memory access ordering and scoreboard compare on every pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      occ      = 0;
      wr_total = 0;
      rd_total = 0;
    end else begin
      check("count_model", 32'(count), occ);
      check("wr_en_is_fire", 32'(wr_if.enable), 32'(push_valid && push_ready));
      if (rd_if.enable) begin
        check("rd_after_wr", 32'(rd_total < wr_total), 1);
        check("rd_addr", 32'(rd_if.addr), rd_total % DEPTH);
        check("rd_wr_en", 32'(rd_if.wr_en), 0);
        rd_total++;
      end
      if (wr_if.enable) begin
        check("wr_addr", 32'(wr_if.addr), wr_total % DEPTH);
        check("wr_data", wr_if.write_data, push_data);
        wr_total++;
      end
      if (pop_valid && pop_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", pop_data, 32'hFFFF_FFFF ^ pop_data);
        end else begin
          check("pop_data", pop_data, sb.pop_front());
        end
        pops++;
        last_pop = pop_data;
      end
      if (push_valid && push_ready) sb.push_back(push_data);
      occ = occ + int'(push_valid && push_ready) - int'(pop_valid && pop_ready);
    end
  end

  task automatic wait_empty(input string name, input int max_cyc);
    int n = 0;
    while (count != '0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(count), 0);
    check({name, "_sb_empty"}, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int p0;
    int start;
    int cyc;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_push_ready", 32'(push_ready), 0);
    check("rst_pop_valid", 32'(pop_valid), 0);
    check("rst_pop_data", pop_data, 0);
    check("rst_count", 32'(count), 0);
    check("rst_wr_enable", 32'(wr_if.enable), 0);
    check("rst_rd_enable", 32'(rd_if.enable), 0);
    check("rst_wr_addr", 32'(wr_if.addr), 0);
    check("rst_rd_addr", 32'(rd_if.addr), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single push, pop_valid three cycles later.
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = 32'hA5A5_A5A5;
    @(negedge clk);
    check("t1_push_ready", 32'(push_ready), 1);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t1_count", 32'(count), 1);
      check("t1_pop_valid", 32'(pop_valid), 32'(c == 3));
    end
    check("t1_pop_data", pop_data, 32'hA5A5_A5A5);
    @(negedge clk);
    check("t1_count_after", 32'(count), 0);
    check("t1_valid_after", 32'(pop_valid), 0);
    @(posedge clk);
    #1;

    // 2: fill with consumer stalled; 18 accepted, then drain in order.
    pop_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_valid = 1'b1;
      push_data  = data_t'(i);
      @(negedge clk);
      check("t2_push_ready", 32'(push_ready), 32'(i < 18));
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t2_count_full", 32'(count), 18);
    check("t2_ready_full", 32'(push_ready), 0);
    @(posedge clk);
    #1;
    p0 = pops;
    pop_ready = 1'b1;
    wait_empty("t2", 100);
    check("t2_pop_total", pops - p0, 18);
    check("t2_last_pop", last_pop, 17);

    // 3: continuous push and pop.
    pop_ready = 1'b1;
    p0 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 100) p0 = pops;
      if (i == 900) check("t3_throughput", pops - p0, 800);
      push_valid = 1'b1;
      push_data  = $urandom;
      @(negedge clk);
      if (i == 500) check("t3_count_steady", 32'(count), 3);
      if (i % 100 == 50) check("t3_push_ready", 32'(push_ready), 1);
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    wait_empty("t3", 50);

    // 4: random valid/ready across several pointer wraps.
    start = wr_total;
    cyc   = 0;
    while ((wr_total - start) < 100 && cyc < 3000) begin
      push_valid = ($urandom_range(0, 1) == 1);
      push_data  = $urandom;
      pop_ready  = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t4_pushes_done", 32'((wr_total - start) >= 100), 1);
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    wait_empty("t4", 100);

    // 5: reset with 10 entries held and a read in flight.
    pop_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push_valid = 1'b1;
      push_data  = data_t'(32'h100 + i);
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pop_ready = 1'b1;
    @(negedge clk);
    check("t5_read_issue", 32'(rd_if.enable), 1);
    @(posedge clk);
    #1;
    pop_ready = 1'b0;
    @(negedge clk);
    check("t5_count_before", 32'(count), 10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_pop_valid", 32'(pop_valid), 0);
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_push_ready", 32'(push_ready), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    push_valid = 1'b1;
    push_data  = 32'h1;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t5_pops_after_rst", pops - p0, 1);
    check("t5_pop_value", last_pop, 32'h1);
    check("t5_count_end", 32'(count), 0);

`ifdef MEM_FIFO_PEAK_EN
    // 6: high-water mark.
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    @(negedge clk);
    check("t6_peak_clr0", 32'(peak_count), 0);
    pop_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_valid = 1'b1;
      push_data  = data_t'(32'h200 + i);
      @(posedge clk);
      #1;
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    wait_empty("t6", 60);
    check("t6_peak_12", 32'(peak_count), 12);
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    @(negedge clk);
    check("t6_peak_cleared", 32'(peak_count), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
